// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// IO-page register word bits and CTRL register bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int IO_UART_DAT_BIT  = 1;
  localparam int IO_UART_CNTL_BIT = 2;
  localparam int CTRL_BUSY_BIT    = 9;
  localparam int CTRL_OVR_BIT     = 8;
  localparam int FRAME_BITS       = 10;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 and pulses bit_done on the last count.
// A synchronous clear restarts the period.
module uart_baud_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_done
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_baud_gen: DIV must be >= 2");
  end

  logic [CW-1:0] cnt_q;

  assign bit_done = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt_q <= '0;
    else if (clr || bit_done)  cnt_q <= '0;
    else                       cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the core's IO page.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO instead of a single holding register.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int IO_PAGE_BIT = 22,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        TXD,
  output logic        busy
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;

  uart_state_e state_q, state_nxt;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic        overrun_q;
  logic        bit_done, baud_clr;
  logic        pending, full;
  logic [7:0]  head;
  logic        wr_req, wr_acc, drop, ctrl_rd, ctrl_sel;
  logic        load_slot, load, enq, deq;
  logic        unused_ok;

  assign ctrl_sel = addr[IO_PAGE_BIT] & addr[2 + IO_UART_CNTL_BIT];
  assign wr_req   = mem_write & addr[IO_PAGE_BIT] & addr[2 + IO_UART_DAT_BIT] & byte_enable[0];
  assign ctrl_rd  = mem_read & ctrl_sel;
  assign wr_acc   = wr_req & ~full;
  assign drop     = wr_req & full;

  // The shifter may take a new character from IDLE or at the end of a stop bit.
  // With nothing queued, an accepted write bypasses the queue straight into the shifter.
  assign load_slot = (state_q == IDLE) | ((state_q == STOP) & bit_done);
  assign load      = load_slot & (pending | wr_acc);
  assign deq       = load & pending;
  assign enq       = wr_acc & ~(load & ~pending);

  assign unused_ok = ^{addr, write_data[31:8], byte_enable[3:1], FIFO_DEPTH[0]};

`ifdef UART_TX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  assign pending = (count_q != '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign head    = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr_q] <= write_data[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;

  assign pending = hold_vld_q;
  assign full    = hold_vld_q;
  assign head    = hold_q;

  always_ff @(posedge clk) begin
    if (enq) hold_q <= write_data[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   hold_vld_q <= 1'b0;
    else if (enq) hold_vld_q <= 1'b1;
    else if (deq) hold_vld_q <= 1'b0;
  end
`endif

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clr      (baud_clr),
    .bit_done (bit_done)
  );

  assign baud_clr = (state_nxt != state_q) | (state_q == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (load) state_nxt = START;
      START:   if (bit_done) state_nxt = DATA;
      DATA:    if (bit_done && bit_idx_q == 3'd7) state_nxt = STOP;
      STOP:    if (bit_done) state_nxt = load ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    TXD = 1'b1;
    case (state_q)
      START:   TXD = 1'b0;
      DATA:    TXD = shift_q[0];
      default: TXD = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load)                               shift_q <= pending ? head : write_data[7:0];
    else if ((state_q == DATA) && bit_done) shift_q <= shift_q >> 1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             bit_idx_q <= 3'd0;
    else if (load)                          bit_idx_q <= 3'd0;
    else if ((state_q == DATA) && bit_done) bit_idx_q <= bit_idx_q + 3'd1;
  end

  // A dropped write wins over a clearing CTRL read on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overrun_q <= 1'b0;
    else if (drop)    overrun_q <= 1'b1;
    else if (ctrl_rd) overrun_q <= 1'b0;
  end

  assign busy = (state_q != IDLE) | pending;

  always_comb begin
    read_data = 32'b0;
    if (ctrl_sel) begin
      read_data[CTRL_BUSY_BIT] = busy;
      read_data[CTRL_OVR_BIT]  = overrun_q;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised self-checking bench for uart_tx_mmio against a frame-schedule
// reference model (each accepted character owns a 10*DIV-cycle slot on the line).
module tb_uart_tx_mmio;
  import uart_pkg::*;

  localparam int DIV       = 10;
  localparam int FRAME_CYC = FRAME_BITS * DIV;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  localparam logic [31:0] A_DAT = 32'h0040_0008;
  localparam logic [31:0] A_CTL = 32'h0040_0010;
  localparam logic [31:0] A_LOW = 32'h0000_0008;
  localparam logic [31:0] A_BTH = 32'h0040_0018;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  byte_enable = 4'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        TXD;
  logic        busy;

  int cyc = 0;
  int tests = 0;
  int failed = 0;

  typedef struct {
    int         acc;
    int         start;
    logic [7:0] d;
  } frame_t;

  frame_t fr_q[$];
  int     drop_q[$];
  int     clr_q[$];

  uart_tx_mmio #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD_RATE   (100_000),
    .IO_PAGE_BIT (22),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .addr        (addr),
    .byte_enable (byte_enable),
    .write_data  (write_data),
    .read_data   (read_data),
    .TXD         (TXD),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Character written at edge t: queued entries are those not yet on the line at t.
  function automatic void model_write(int t, logic [7:0] d);
    int occ = 0;
    int s = t;
    foreach (fr_q[i]) begin
      if (fr_q[i].start >= t) occ++;
      if (fr_q[i].start + FRAME_CYC > s) s = fr_q[i].start + FRAME_CYC;
    end
    if (occ >= CAP) drop_q.push_back(t);
    else fr_q.push_back('{acc: t, start: s, d: d});
  endfunction

  function automatic logic exp_txd(int c);
    int k;
    foreach (fr_q[i]) begin
      if (fr_q[i].start <= c && c < fr_q[i].start + FRAME_CYC) begin
        k = (c - fr_q[i].start) / DIV;
        if (k == 0) return 1'b0;
        if (k == FRAME_BITS - 1) return 1'b1;
        return fr_q[i].d[k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int c);
    foreach (fr_q[i])
      if (fr_q[i].acc <= c && c < fr_q[i].start + FRAME_CYC) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_ovr(int c);
    int ld = -1;
    int lc = -1;
    foreach (drop_q[i]) if (drop_q[i] <= c && drop_q[i] > ld) ld = drop_q[i];
    foreach (clr_q[i]) if (clr_q[i] <= c && clr_q[i] > lc) lc = clr_q[i];
    return (ld >= 0) && (ld >= lc);
  endfunction

  function automatic logic [31:0] exp_rd(int c);
    logic [31:0] r = 32'h0;
    r[CTRL_BUSY_BIT] = exp_busy(c);
    r[CTRL_OVR_BIT]  = exp_ovr(c);
    return r;
  endfunction

  function automatic void model_clear();
    fr_q.delete();
    drop_q.delete();
    clr_q.delete();
  endfunction

  // One bus cycle: drive just after the edge; the DUT samples it on the next edge.
  task automatic drive_cycle(input logic wr, input logic [31:0] a, input logic [7:0] d,
                             input logic [3:0] be, input logic rd);
    logic [23:0] hi;
    @(posedge clk);
    #1;
    hi = 24'($urandom);
    mem_write   = wr;
    mem_read    = rd;
    addr        = a;
    write_data  = {hi, d};
    byte_enable = be;
    if (wr && a[22] && a[3] && be[0]) model_write(cyc + 1, d);
    if (rd && a[22] && a[4]) clr_q.push_back(cyc + 1);
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 32'h0, 8'h0, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (TXD !== 1'b1) begin failed++; $display("FAIL rst_txd_held got=%b exp=1", TXD); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_busy_held got=%b exp=0", busy); end
    @(posedge clk);
    #1 reset = 1'b1;
    drive_cycle(1'b0, A_CTL, 8'h0, 4'h0, 1'b1);
    @(negedge clk);
    tests++; if (TXD !== 1'b1) begin failed++; $display("FAIL rst_txd got=%b exp=1", TXD); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tests++; if (read_data !== 32'h0) begin failed++; $display("FAIL rst_ctrl got=%h exp=00000000", read_data); end
  endtask

  task automatic test_single();
    logic [9:0] cells = 10'b1010101010;
    int t0;
    drive_cycle(1'b1, A_DAT, 8'h55, 4'b0001, 1'b0);
    t0 = cyc + 1;
    for (int i = 0; i < FRAME_CYC + 15; i++) begin
      idle_cycle();
      @(negedge clk);
      tests++; if (TXD !== exp_txd(cyc)) begin failed++; $display("FAIL single_txd cyc=%0d got=%b exp=%b", cyc, TXD, exp_txd(cyc)); end
      tests++; if (busy !== exp_busy(cyc)) begin failed++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy(cyc)); end
      if (cyc >= t0 && cyc < t0 + FRAME_CYC && (cyc - t0) % DIV == DIV / 2) begin
        tests++;
        if (TXD !== cells[(cyc - t0) / DIV]) begin
          failed++; $display("FAIL single_cell cell=%0d got=%b exp=%b", (cyc - t0) / DIV, TXD, cells[(cyc - t0) / DIV]);
        end
      end
      if (cyc == t0 + FRAME_CYC - 1 || cyc == t0 + FRAME_CYC) begin
        tests++;
        if (busy !== (cyc == t0 + FRAME_CYC - 1)) begin
          failed++; $display("FAIL single_busy_edge cyc=%0d got=%b", cyc - t0, busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0 = 0;
    for (int i = 0; i < 2 * FRAME_CYC + 15; i++) begin
      if (i == 0) drive_cycle(1'b1, A_DAT, 8'hA5, 4'b0001, 1'b0);
      else if (i == 1) drive_cycle(1'b1, A_DAT, 8'h3C, 4'b0001, 1'b0);
      else idle_cycle();
      if (i == 0) t0 = cyc + 1;
      @(negedge clk);
      tests++; if (TXD !== exp_txd(cyc)) begin failed++; $display("FAIL b2b_txd cyc=%0d got=%b exp=%b", cyc, TXD, exp_txd(cyc)); end
      tests++; if (busy !== exp_busy(cyc)) begin failed++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy(cyc)); end
      if (cyc >= t0 && cyc <= t0 + 2 * FRAME_CYC) begin
        tests++;
        if (busy !== (cyc < t0 + 2 * FRAME_CYC)) begin
          failed++; $display("FAIL b2b_busy_span rel=%0d got=%b", cyc - t0, busy);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic rd;
    for (int i = 0; i < (CAP + 1) * FRAME_CYC + 20; i++) begin
      rd = (i == 20 || i == 21);
      if (i <= CAP + 1) drive_cycle(1'b1, A_DAT, 8'($urandom), 4'b0001, 1'b0);
      else drive_cycle(1'b0, A_CTL, 8'h0, 4'h0, rd);
      @(negedge clk);
      tests++; if (TXD !== exp_txd(cyc)) begin failed++; $display("FAIL ovr_txd cyc=%0d got=%b exp=%b", cyc, TXD, exp_txd(cyc)); end
      tests++; if (busy !== exp_busy(cyc)) begin failed++; $display("FAIL ovr_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy(cyc)); end
      if (i == 20) begin
        tests++; if (read_data !== 32'h0000_0300) begin failed++; $display("FAIL ovr_ctrl_set got=%h exp=00000300", read_data); end
      end
      if (i == 21) begin
        tests++; if (read_data !== 32'h0000_0200) begin failed++; $display("FAIL ovr_ctrl_clr got=%h exp=00000200", read_data); end
      end
    end
  endtask

  task automatic test_ignored();
    for (int i = 0; i < 40; i++) begin
      case (i)
        0:       drive_cycle(1'b1, A_DAT, 8'h81, 4'b0010, 1'b0);
        2:       drive_cycle(1'b1, A_LOW, 8'h42, 4'b0001, 1'b0);
        4:       drive_cycle(1'b1, A_CTL, 8'h99, 4'b0001, 1'b0);
        10:      drive_cycle(1'b0, A_CTL, 8'h0, 4'h0, 1'b1);
        default: idle_cycle();
      endcase
      @(negedge clk);
      tests++; if (TXD !== 1'b1) begin failed++; $display("FAIL ign_txd cyc=%0d got=%b exp=1", cyc, TXD); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL ign_busy cyc=%0d got=%b exp=0", cyc, busy); end
      if (i == 10) begin
        tests++; if (read_data !== 32'h0) begin failed++; $display("FAIL ign_ctrl got=%h exp=00000000", read_data); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'($urandom) & 8'hFB;
    drive_cycle(1'b1, A_DAT, d, 4'b0001, 1'b0);
    for (int i = 0; i < 36; i++) begin
      idle_cycle();
      @(negedge clk);
      tests++; if (TXD !== exp_txd(cyc)) begin failed++; $display("FAIL mid_txd cyc=%0d got=%b exp=%b", cyc, TXD, exp_txd(cyc)); end
      tests++; if (busy !== exp_busy(cyc)) begin failed++; $display("FAIL mid_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy(cyc)); end
    end
    reset = 1'b0;
    model_clear();
    #1;
    tests++; if (TXD !== 1'b1) begin failed++; $display("FAIL mid_rst_txd got=%b exp=1", TXD); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < FRAME_CYC + 20; i++) begin
      if (i == 50) drive_cycle(1'b0, A_CTL, 8'h0, 4'h0, 1'b1);
      else idle_cycle();
      @(negedge clk);
      tests++; if (TXD !== 1'b1) begin failed++; $display("FAIL post_rst_txd cyc=%0d got=%b exp=1", cyc, TXD); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL post_rst_busy cyc=%0d got=%b exp=0", cyc, busy); end
      if (i == 50) begin
        tests++; if (read_data !== 32'h0) begin failed++; $display("FAIL post_rst_ctrl got=%h exp=00000000", read_data); end
      end
    end
  endtask

  task automatic test_random();
    logic        wr, rd;
    logic [31:0] a;
    logic [3:0]  be;
    for (int i = 0; i < 2000; i++) begin
      wr = (i < 1400) && ($urandom_range(0, 29) == 0);
      rd = !wr && ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 5))
        0:       a = A_LOW;
        1:       a = A_CTL;
        2:       a = A_BTH;
        default: a = A_DAT;
      endcase
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0001;
      if (rd) a = A_CTL;
      drive_cycle(wr, a, 8'($urandom), be, rd);
      @(negedge clk);
      tests++; if (TXD !== exp_txd(cyc)) begin failed++; $display("FAIL rnd_txd cyc=%0d got=%b exp=%b", cyc, TXD, exp_txd(cyc)); end
      tests++; if (busy !== exp_busy(cyc)) begin failed++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy(cyc)); end
      if (rd) begin
        tests++; if (read_data !== exp_rd(cyc)) begin failed++; $display("FAIL rnd_ctrl cyc=%0d got=%h exp=%h", cyc, read_data, exp_rd(cyc)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_ignored();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
